// File: rtl/psram_pkg.sv
// Shared encodings and widths for the synchronous-burst PSRAM controller.
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        END
    } state_t;

    localparam int PSRAM_ADR_W = 23;
    localparam int PSRAM_DAT_W = 16;
    localparam int LOCAL_ADR_W = 16;

endpackage

// File: rtl/psram_burst_controller_if.sv
// Local-bus request signals and PSRAM pin group; master = controller side.
interface psram_burst_controller_if;
    import psram_pkg::*;

    logic [LOCAL_ADR_W-1:0] adr_i;
    logic [PSRAM_DAT_W-1:0] dat_i;
    logic [PSRAM_DAT_W-1:0] dat_o;
    logic                   start_i;
    logic                   we_i;
    logic                   psram_clk;
    logic [PSRAM_ADR_W-1:0] psram_adr;
    logic [PSRAM_DAT_W-1:0] psram_dat_o;
    logic [PSRAM_DAT_W-1:0] psram_dat_i;
    logic                   psram_data_oe;
    logic                   psram_we_n;
    logic                   psram_ce_n;
    logic                   psram_adv_n;
    logic                   psram_oe_n;

    modport master (
        input  adr_i, dat_i, start_i, we_i, psram_dat_i,
        output dat_o, psram_clk, psram_adr, psram_dat_o, psram_data_oe,
               psram_we_n, psram_ce_n, psram_adv_n, psram_oe_n
    );

    modport slave (
        output adr_i, dat_i, start_i, we_i, psram_dat_i,
        input  dat_o, psram_clk, psram_adr, psram_dat_o, psram_data_oe,
               psram_we_n, psram_ce_n, psram_adv_n, psram_oe_n
    );

endinterface

// File: rtl/psram_clk_gate.sv
// Latch-based gate: psram_clk = clk_en AND NOT clk_i, enable captured while clk_i is high.
module psram_clk_gate (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clk_en,
    output logic psram_clk
);

    logic en_l;

    // Transparent in the high phase so the enable is frozen for the whole low (output) phase.
    always_latch begin
        if (!rst_n)
            en_l = 1'b0;
        else if (clk_i)
            en_l = clk_en;
    end

    assign psram_clk = en_l & ~clk_i;

endmodule

// File: rtl/psram_burst_controller.sv
// Fixed-length burst master for a CellularRAM-style PSRAM.
// Optional status outputs busy_o/valid_o are built when PSRAM_STATUS_EN is defined.
module psram_burst_controller
    import psram_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    psram_burst_controller_if.master bus
`ifdef PSRAM_STATUS_EN
    ,
    output logic busy_o,
    output logic valid_o
`endif
);

    localparam int ADR_SHIFT = $clog2(BURST_LEN);
    localparam int BEAT_W    = (ADR_SHIFT > 0) ? ADR_SHIFT : 1;
    localparam int WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 state_q, state_d;
    logic                   we_q;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   clk_en;
    logic                   ce_n, adv_n, we_n, oe_n, data_oe;
    logic [PSRAM_ADR_W-1:0] psram_adr;
    logic [PSRAM_DAT_W-1:0] psram_dat_o;
    logic [PSRAM_DAT_W-1:0] dat_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = ADDR;
            ADDR:    state_d = WAIT;
            WAIT:    if (wait_cnt == '0) state_d = DATA;
            DATA:    if (beat_cnt == BEAT_W'(BURST_LEN - 1)) state_d = END;
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin strobes are registered from the next state so they change only on clk_i rising edges.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q        <= 1'b0;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            clk_en      <= 1'b0;
            ce_n        <= 1'b1;
            adv_n       <= 1'b1;
            we_n        <= 1'b1;
            oe_n        <= 1'b1;
            data_oe     <= 1'b0;
            psram_adr   <= '0;
            psram_dat_o <= '0;
            dat_o       <= '0;
        end else begin
            ce_n    <= !(state_d inside {ADDR, WAIT, DATA});
            clk_en  <= state_d inside {ADDR, WAIT, DATA};
            adv_n   <= (state_d != ADDR);
            we_n    <= !(state_d == ADDR && bus.we_i);
            oe_n    <= !(state_d inside {WAIT, DATA} && !we_q);
            data_oe <= (state_d == DATA) && we_q;

            if (state_q == IDLE && state_d == ADDR) begin
                we_q      <= bus.we_i;
                psram_adr <= PSRAM_ADR_W'(bus.adr_i) << ADR_SHIFT;
            end

            if (state_q == ADDR)
                wait_cnt <= WAIT_W'(LATENCY - 1);
            else if (state_q == WAIT)
                wait_cnt <= wait_cnt - 1'b1;

            if (state_q == WAIT)
                beat_cnt <= '0;
            else if (state_q == DATA)
                beat_cnt <= beat_cnt + 1'b1;

            if (state_d == DATA && we_q)
                psram_dat_o <= bus.dat_i;
            if (state_q == DATA && !we_q)
                dat_o <= bus.psram_dat_i;
        end
    end

    psram_clk_gate u_clk_gate (
        .clk_i     (clk_i),
        .rst_n     (rst_i),
        .clk_en    (clk_en),
        .psram_clk (bus.psram_clk)
    );

    assign bus.psram_ce_n    = ce_n;
    assign bus.psram_adv_n   = adv_n;
    assign bus.psram_we_n    = we_n;
    assign bus.psram_oe_n    = oe_n;
    assign bus.psram_data_oe = data_oe;
    assign bus.psram_adr     = psram_adr;
    assign bus.psram_dat_o   = psram_dat_o;
    assign bus.dat_o         = dat_o;

`ifdef PSRAM_STATUS_EN
    logic valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            valid_q <= 1'b0;
        else
            valid_q <= (state_q == DATA) && !we_q;
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
`endif

endmodule

// File: tb/tb_psram_burst_controller.sv
// Randomized self-checking bench for psram_burst_controller against a burst-timeline model.
module tb_psram_burst_controller;

    localparam int BL = 4;
    localparam int LAT = 3;
    localparam int NB = LAT + BL + 2;   // cycles per burst
    localparam int NT = NB + 2;         // samples recorded per burst (t = 0..NT-1)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psram_burst_controller_if bus ();

`ifdef PSRAM_STATUS_EN
    logic busy, valid;
`endif

    psram_burst_controller #(.BURST_LEN(BL), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
`ifdef PSRAM_STATUS_EN
        ,
        .busy_o  (busy),
        .valid_o (valid)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_dat_o = '0;

    logic [5:0]  obs_ctrl [NT];
    logic [22:0] obs_adr  [NT];
    logic [15:0] obs_pdo  [NT];
    logic [15:0] obs_dato [NT];
    logic        obs_busy [NT];
    logic        obs_valid[NT];
    logic [15:0] drv_w    [NT+1];   // drv_w[i] = dat_i driven during cycle i-1
    logic [15:0] drv_r    [NT];

    // Expected {ce_n, adv_n, we_n, oe_n, data_oe, psram_clk} at cycle t of a burst (t=0 is ADDR).
    function automatic logic [5:0] exp_ctrl(input int t, input bit we);
        bit act, adr_ph, wait_ph, data_ph;
        act     = (t >= 0) && (t <= LAT + BL);
        adr_ph  = (t == 0);
        wait_ph = (t >= 1) && (t <= LAT);
        data_ph = (t > LAT) && (t <= LAT + BL);
        return {!act, !adr_ph, !(adr_ph && we), !((wait_ph || data_ph) && !we), data_ph && we, act};
    endfunction

    function automatic bit is_data(input int t);
        return (t > LAT) && (t <= LAT + BL);
    endfunction

    task automatic run_burst(input logic [15:0] adr, input bit we, input bit hold,
                             input int ign_t, input int rbase);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.adr_i = adr;
        bus.we_i = we;
        drv_w[0] = 16'($urandom);
        bus.dat_i = drv_w[0];
        bus.psram_dat_i = 16'($urandom);
        for (int t = 0; t < NT; t++) begin
            @(negedge clk);
            obs_ctrl[t] = {bus.psram_ce_n, bus.psram_adv_n, bus.psram_we_n,
                           bus.psram_oe_n, bus.psram_data_oe, bus.psram_clk};
            obs_adr[t]  = bus.psram_adr;
            obs_pdo[t]  = bus.psram_dat_o;
            obs_dato[t] = bus.dat_o;
`ifdef PSRAM_STATUS_EN
            obs_busy[t]  = busy;
            obs_valid[t] = valid;
`else
            obs_busy[t]  = 1'b0;
            obs_valid[t] = 1'b0;
`endif
            bus.start_i = hold || (t == ign_t);
            bus.adr_i = 16'($urandom);
            bus.we_i = hold ? we : 1'($urandom);
            drv_w[t+1] = 16'($urandom);
            bus.dat_i = drv_w[t+1];
            drv_r[t] = (rbase >= 0) ? 16'(rbase + t - LAT - 1) : 16'($urandom);
            bus.psram_dat_i = drv_r[t];
        end
        bus.start_i = 1'b0;
        if (hold) repeat (NB) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start_i = 1'b1;
        bus.we_i = 1'b1;
        bus.adr_i = 16'hFFFF;
        bus.dat_i = 16'hAAAA;
        bus.psram_dat_i = 16'h5555;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.psram_ce_n, bus.psram_adv_n, bus.psram_we_n, bus.psram_oe_n,
                 bus.psram_data_oe, bus.psram_clk} !== 6'b111100) begin
                failures++;
                $display("FAIL reset_ctrl cycle %0d: got %b want 111100", i,
                         {bus.psram_ce_n, bus.psram_adv_n, bus.psram_we_n,
                          bus.psram_oe_n, bus.psram_data_oe, bus.psram_clk});
            end
            checks++;
            if (bus.psram_adr !== 23'h0 || bus.psram_dat_o !== 16'h0 || bus.dat_o !== 16'h0) begin
                failures++;
                $display("FAIL reset_data: adr=%h dat_o_pin=%h dat_o=%h want 0", bus.psram_adr,
                         bus.psram_dat_o, bus.dat_o);
            end
        end
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.psram_ce_n !== 1'b1 || bus.psram_clk !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: ce_n=%b psram_clk=%b want 1/0", bus.psram_ce_n, bus.psram_clk);
        end
        exp_dat_o = '0;
    endtask

    task automatic test_write(input logic [15:0] adr);
        logic [22:0] ea;
        ea = 23'(adr) << 2;
        run_burst(adr, 1'b1, 1'b0, -1, -1);
        if (adr == 16'hD687) begin
            checks++;
            if (obs_adr[0] !== 23'h35A1C) begin
                failures++;
                $display("FAIL write_addr_const: got %h want 35a1c", obs_adr[0]);
            end
        end
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (obs_ctrl[t] !== exp_ctrl(t, 1'b1)) begin
                failures++;
                $display("FAIL write_ctrl t=%0d: got %b want %b", t, obs_ctrl[t], exp_ctrl(t, 1'b1));
            end
            checks++;
            if (obs_adr[t] !== ea) begin
                failures++;
                $display("FAIL write_adr t=%0d: got %h want %h", t, obs_adr[t], ea);
            end
            if (is_data(t)) begin
                checks++;
                if (obs_pdo[t] !== drv_w[t]) begin
                    failures++;
                    $display("FAIL write_data t=%0d: got %h want %h", t, obs_pdo[t], drv_w[t]);
                end
            end
            checks++;
            if (obs_dato[t] !== exp_dat_o) begin
                failures++;
                $display("FAIL write_keeps_dat_o t=%0d: got %h want %h", t, obs_dato[t], exp_dat_o);
            end
        end
    endtask

    task automatic test_read(input logic [15:0] adr, input int rbase);
        logic [22:0] ea;
        ea = 23'(adr) << 2;
        run_burst(adr, 1'b0, 1'b0, -1, rbase);
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (obs_ctrl[t] !== exp_ctrl(t, 1'b0)) begin
                failures++;
                $display("FAIL read_ctrl t=%0d: got %b want %b", t, obs_ctrl[t], exp_ctrl(t, 1'b0));
            end
            checks++;
            if (obs_adr[t] !== ea) begin
                failures++;
                $display("FAIL read_adr t=%0d: got %h want %h", t, obs_adr[t], ea);
            end
            checks++;
            if (obs_dato[t] !== exp_dat_o) begin
                failures++;
                $display("FAIL read_dat_o t=%0d: got %h want %h", t, obs_dato[t], exp_dat_o);
            end
`ifdef PSRAM_STATUS_EN
            checks++;
            if (obs_busy[t] !== (t <= LAT + BL + 1) || obs_valid[t] !== is_data(t - 1)) begin
                failures++;
                $display("FAIL read_status t=%0d: busy=%b valid=%b want %b %b", t, obs_busy[t],
                         obs_valid[t], (t <= LAT + BL + 1), is_data(t - 1));
            end
`endif
            if (is_data(t)) exp_dat_o = drv_r[t];
        end
        if (rbase >= 0) begin
            checks++;
            if (obs_dato[NT-1] !== 16'(rbase + BL - 1)) begin
                failures++;
                $display("FAIL read_last_beat: got %0d want %0d", obs_dato[NT-1], rbase + BL - 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        run_burst(16'($urandom), 1'b1, 1'b0, 2, -1);
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (obs_ctrl[t] !== exp_ctrl(t, 1'b1)) begin
                failures++;
                $display("FAIL ignored_start_ctrl t=%0d: got %b want %b", t, obs_ctrl[t], exp_ctrl(t, 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int tp;
        run_burst(16'($urandom), 1'b1, 1'b1, -1, -1);
        for (int t = 0; t < NT; t++) begin
            tp = (t >= NB + 1) ? t - (NB + 1) : t;
            checks++;
            if (obs_ctrl[t] !== exp_ctrl(tp, 1'b1)) begin
                failures++;
                $display("FAIL back_to_back_ctrl t=%0d: got %b want %b", t, obs_ctrl[t], exp_ctrl(tp, 1'b1));
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.we_i = 1'b1;
        bus.adr_i = 16'($urandom);
        for (int t = 0; t <= LAT + 2; t++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.dat_i = 16'($urandom) | 16'h0001;
        end
        checks++;
        if (bus.psram_data_oe !== 1'b1 || bus.psram_clk !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_precond: data_oe=%b psram_clk=%b want 1/1", bus.psram_data_oe, bus.psram_clk);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.psram_ce_n, bus.psram_adv_n, bus.psram_we_n, bus.psram_oe_n,
             bus.psram_data_oe, bus.psram_clk} !== 6'b111100) begin
            failures++;
            $display("FAIL mid_reset_ctrl: got %b want 111100",
                     {bus.psram_ce_n, bus.psram_adv_n, bus.psram_we_n, bus.psram_oe_n,
                      bus.psram_data_oe, bus.psram_clk});
        end
        checks++;
        if (bus.psram_adr !== 23'h0 || bus.psram_dat_o !== 16'h0 || bus.dat_o !== 16'h0) begin
            failures++;
            $display("FAIL mid_reset_data: adr=%h dat_o_pin=%h dat_o=%h want 0", bus.psram_adr,
                     bus.psram_dat_o, bus.dat_o);
        end
        exp_dat_o = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.psram_ce_n !== 1'b1 || bus.psram_adv_n !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_no_resume: ce_n=%b adv_n=%b want 1/1", bus.psram_ce_n, bus.psram_adv_n);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.we_i = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.psram_dat_i = '0;
        test_reset();
        test_write(16'hD687);
        test_read(16'd256, 100);
        for (int i = 0; i < 3; i++) begin
            test_write(16'($urandom));
            test_read(16'($urandom), -1);
        end
        test_ignored_start();
        test_back_to_back();
        test_read(16'($urandom), -1);
        test_mid_reset();
        test_read(16'($urandom), -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_burst_controller.md
Name: psram_burst_controller

Overview:
- Single-clock master for a synchronous-burst CellularRAM-style PSRAM.
- Each start_i pulse runs one fixed-length burst: address latch, fixed initial latency, then BURST_LEN data beats, in the direction set by we_i.
- Sits between a simple local-bus requester (adr_i/dat_i/dat_o/start_i/we_i) and the PSRAM pins. The bidirectional data bus is split into psram_dat_o, psram_dat_i and psram_data_oe; the pad tristate lives at top level.

Parameters:
- BURST_LEN, 4: data beats per burst; power of two, 2..16.
- LATENCY, 3: wait cycles between the address phase and the first data beat; must be >= 1.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- adr_i  in  16  burst block address; sampled only when a burst starts.
- dat_i  in  16  write data, one word per beat.
- dat_o  out  16  read data; last captured beat.
- start_i  in  1  burst request; honoured only in IDLE.
- we_i  in  1  1 = write burst, 0 = read burst; sampled with start_i.
- psram_clk  out  1  PSRAM clock.
- psram_adr  out  23  PSRAM word address.
- psram_dat_o  out  16  data driven to PSRAM.
- psram_dat_i  in  16  data from PSRAM.
- psram_data_oe  out  1  1 = top level enables the psram_dat_o pad drivers.
- psram_we_n  out  1  PSRAM WE#, active low.
- psram_ce_n  out  1  PSRAM CE#, active low.
- psram_adv_n  out  1  PSRAM ADV#, active low.
- psram_oe_n  out  1  PSRAM OE#, active low.

Behaviour:
- Reset (rst_i=0, asynchronous), all outputs inactive:
  - psram_ce_n, psram_adv_n, psram_oe_n, psram_we_n = 1.
  - psram_data_oe = 0, psram_clk = 0.
  - psram_adr, psram_dat_o, dat_o = 0.
  - State = IDLE.
- Reset asserted mid-burst aborts immediately to these values, with no completion.
- IDLE: all strobes inactive; psram_clk held at 0.
  - start_i=1 at a rising edge: latch adr_i and we_i, go to ADDR.
- ADDR (1 cycle):
  - psram_ce_n=0, psram_adv_n=0.
  - psram_adr = {5'b0, adr_i, log2(BURST_LEN) zero bits}; with defaults, adr_i << 2. psram_adr is registered and held for the whole burst.
  - psram_we_n = 0 for a write burst, 1 for a read burst.
  - Next state: WAIT.
- WAIT (LATENCY cycles, down-counter):
  - psram_ce_n=0, psram_adv_n=1, psram_we_n=1.
  - psram_oe_n=0 if read, else 1.
  - Next state: DATA.
- DATA (BURST_LEN cycles, beat counter 0..BURST_LEN-1):
  - psram_ce_n=0.
  - Write: psram_data_oe=1. psram_dat_o is registered: it loads dat_i on every rising edge whose next state is DATA. The word on dat_i in the cycle before beat k is therefore written at beat k.
  - Read: psram_oe_n=0. dat_o loads psram_dat_i on every rising edge that ends a DATA cycle.
  - After the last beat, go to END.
- END (1 cycle):
  - All strobes inactive, psram_data_oe=0, psram_clk stopped. This cycle is the CE# recovery.
  - Next state: IDLE.
- Total burst length = 1 + LATENCY + BURST_LEN + 1 cycles; 9 cycles with defaults.
- psram_clk = clk_en AND NOT clk_i, with glitch-free gating.
  - clk_en is a register that is 1 in ADDR, WAIT and DATA.
  - The PSRAM therefore samples mid-cycle, half a period after the controller updates its outputs.
- dat_o holds the last read beat until the next read burst overwrites it; write bursts never change dat_o.
- start_i outside IDLE (ADDR/WAIT/DATA/END) is ignored and not queued.
- adr_i and we_i changes during a burst have no effect.
- Held-high start_i: a new burst begins on the first edge back in IDLE, so there is exactly one idle cycle between bursts.

Optional Feature:
- Macro PSRAM_STATUS_EN.
- Defined: two extra outputs.
  - busy_o: 1 in every state except IDLE.
  - valid_o: 1-cycle pulse in the cycle after each read beat is captured into dat_o.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package psram_pkg holds:
  - state encoding: IDLE, ADDR, WAIT, DATA, END;
  - PSRAM_ADR_W=23, PSRAM_DAT_W=16, LOCAL_ADR_W=16.
- Sub-module psram_clk_gate: latch-based clock gate producing psram_clk from clk_i and clk_en.
- FSM, counters and data registers stay in the top module.

Test Plan:
- Reset: rst_i=0 with start_i=1 -> ce_n/adv_n/oe_n/we_n=1, data_oe=0, psram_clk=0, psram_adr=0, dat_o=0; state stays IDLE.
- Write burst: adr_i=0xD687, we_i=1, 1-cycle start_i, dat_i=0x0041,0x0042,... each cycle ->
  - ADDR cycle: psram_adr=0x35A1C, adv_n=0, we_n=0.
  - 3 WAIT cycles.
  - 4 DATA cycles with data_oe=1 and psram_dat_o = the dat_i value of the preceding cycle.
  - ce_n=1 on cycle 9.
- Read burst: adr_i=256, we_i=0, psram_dat_i incrementing from 100 ->
  - psram_adr=0x400, oe_n=0 through WAIT and DATA, data_oe=0.
  - dat_o ends equal to the psram_dat_i value of the 4th DATA cycle.
- Ignored start: start_i=1 during WAIT of a write -> burst still ends after 9 cycles; no second ADDR cycle follows.
- Mid-burst reset: rst_i=0 in the 2nd DATA cycle -> outputs return to reset values immediately, without waiting for the next clock edge.
- Back-to-back: start_i held high -> ADDR cycles 10 cycles apart; psram_clk idle (0) during END and IDLE.
